// File: rtl/dac_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : dac_cmd_queue
// Purpose  : Command FIFO and dispatcher that feeds the DAC SPI serializer.
//            Words {comm, addr, data} are queued. One word at a time is
//            presented on dac_comm/addr/data, a one-cycle dac_start pulse is
//            issued, and the next word is held back until the serializer's
//            spi_enable has risen and fallen and an idle gap has elapsed.
// Ports    : clk, rst (async, active high)
//            wr_en, wr_comm, wr_addr, wr_data   - push side
//            run, clr_err                       - control
//            spi_enable                         - serializer frame-active
//            dac_comm, dac_addr, dac_data       - held word to serializer
//            dac_start                          - start pulse (ext_ctrl)
//            full, empty, count                 - FIFO status
//            busy, err_ovf, err_tmo, sent_cnt   - dispatcher status
// Revision : 1.0 - initial release
// ============================================================================
module dac_cmd_queue #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 128,
  parameter int GAP_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [3:0]    wr_comm,
  input  logic [3:0]    wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          run,
  input  logic          clr_err,
  input  logic          spi_enable,
  output logic [3:0]    dac_comm,
  output logic [3:0]    dac_addr,
  output logic [15:0]   dac_data,
  output logic          dac_start,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          err_ovf,
  output logic          err_tmo,
  output logic [15:0]   sent_cnt
);

  // A GAP_CYC of 0 still spends one cycle in GAP.
  localparam int c_gap_n = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int c_gw    = (c_gap_n > 1) ? $clog2(c_gap_n) : 1;
  localparam int c_tw    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [23:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  logic              r_full;
  logic              r_empty;

  logic [c_tw-1:0]   r_timer;
  logic [c_gw-1:0]   r_gap;
  logic [3:0]        r_dac_comm;
  logic [3:0]        r_dac_addr;
  logic [15:0]       r_dac_data;
  logic              r_dac_start;
  logic              r_err_ovf;
  logic              r_err_tmo;
  logic [15:0]       r_sent_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_ovf;
  logic              w_tmo;
  logic              w_done;

  // A pop frees a slot in the same cycle, so a push while full is accepted
  // whenever the dispatcher is popping.
  assign w_pop  = (r_state == ST_IDLE) && run && !r_empty;
  assign w_push = wr_en && (!r_full || w_pop);
  assign w_ovf  = wr_en && r_full && !w_pop;
  assign w_tmo  = (r_state == ST_WAIT_BUSY) && !spi_enable &&
                  (r_timer == c_tw'(TIMEOUT - 1));
  assign w_done = (r_state == ST_WAIT_DONE) && !spi_enable;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_comm, wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_pop) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:    w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (spi_enable)  w_state_nxt = ST_WAIT_DONE;
        else if (w_tmo)  w_state_nxt = ST_GAP;
      end
      ST_WAIT_DONE: if (!spi_enable) w_state_nxt = ST_GAP;
      ST_GAP:       if (r_gap == c_gw'(c_gap_n - 1)) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_gap       <= '0;
      r_dac_comm  <= '0;
      r_dac_addr  <= '0;
      r_dac_data  <= '0;
      r_dac_start <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_sent_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Start is issued for the cycle following the pop, i.e. while in LAUNCH.
      r_dac_start <= w_pop;
      if (w_pop) begin
        {r_dac_comm, r_dac_addr, r_dac_data} <= r_mem[r_rd_ptr];
      end

      if (r_state == ST_LAUNCH) begin
        r_timer <= '0;
      end else if ((r_state == ST_WAIT_BUSY) && !spi_enable && !w_tmo) begin
        r_timer <= r_timer + c_tw'(1);
      end

      if (r_state != ST_GAP) r_gap <= '0;
      else                   r_gap <= r_gap + c_gw'(1);

      if (w_done) r_sent_cnt <= r_sent_cnt + 16'd1;

      // A new error in the same cycle as clr_err takes priority.
      if (w_ovf)        r_err_ovf <= 1'b1;
      else if (clr_err) r_err_ovf <= 1'b0;

      if (w_tmo)        r_err_tmo <= 1'b1;
      else if (clr_err) r_err_tmo <= 1'b0;
    end
  end

  assign dac_comm  = r_dac_comm;
  assign dac_addr  = r_dac_addr;
  assign dac_data  = r_dac_data;
  assign dac_start = r_dac_start;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign busy      = (r_state != ST_IDLE);
  assign err_ovf   = r_err_ovf;
  assign err_tmo   = r_err_tmo;
  assign sent_cnt  = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_cmd_queue
// Purpose  : Self-checking bench for dac_cmd_queue. A stimulus process
//            pushes words and queues expected values; a monitor process
//            compares every dac_start word in push order and evaluates all
//            queued status expectations. A small serializer model answers
//            each start with a spi_enable frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_cmd_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk, rst, wr_en, run, clr_err, spi_enable;
  logic [3:0]  wr_comm, wr_addr, dac_comm, dac_addr;
  logic [15:0] wr_data, dac_data, sent_cnt;
  logic        dac_start, full, empty, busy, err_ovf, err_tmo;
  logic [AW:0] count;

  dac_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(128), .GAP_CYC(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_comm(wr_comm), .wr_addr(wr_addr),
    .wr_data(wr_data), .run(run), .clr_err(clr_err), .spi_enable(spi_enable),
    .dac_comm(dac_comm), .dac_addr(dac_addr), .dac_data(dac_data),
    .dac_start(dac_start), .full(full), .empty(empty), .count(count),
    .busy(busy), .err_ovf(err_ovf), .err_tmo(err_tmo), .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } req_t;

  req_t        req_q[$];     // status expectations, filled by stimulus
  logic [23:0] exp_w[$];     // accepted words in push order
  int          n_acc  = 0;   // words accepted by the model FIFO
  int          n_starts = 0; // dac_start pulses observed
  int          last_start_cyc = 0;
  bit          done = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  // serializer model controls
  bit tmo_mode  = 1'b0;
  bit use_fixed = 1'b0;
  int fix_delay = 40;
  int fix_len   = 25;
  bit ser_active = 1'b0;

  task automatic expect_eq(input string nm, input logic [31:0] a, input logic [31:0] e);
    req_t r;
    r.name = nm;
    r.act  = a;
    r.exp  = e;
    req_q.push_back(r);
  endtask

  // ---------------- monitor / checker ----------------
  task automatic do_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  bit prev_start = 1'b0;
  always @(negedge clk) begin
    req_t r;
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (dac_start) begin
        do_chk("start_not_consecutive", 32'(prev_start), 32'd0);
        do_chk("start_while_spi_idle", 32'(spi_enable), 32'd0);
        if (n_starts >= exp_w.size())
          do_chk("unexpected_start", 32'd1, 32'd0);
        else
          do_chk("dispatched_word", 32'({dac_comm, dac_addr, dac_data}),
                 32'(exp_w[n_starts]));
        n_starts++;
        last_start_cyc = cyc;
      end
      prev_start = dac_start;
    end
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      do_chk(r.name, r.act, r.exp);
    end
    if (cyc > 60000) begin
      do_chk("global_watchdog", 32'd1, 32'd0);
      done = 1'b1;
    end
    if (done) begin
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end

  // ---------------- serializer model ----------------
  initial begin
    int d, l;
    spi_enable = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && dac_start && !tmo_mode) begin
        ser_active = 1'b1;
        d = use_fixed ? fix_delay : int'($urandom_range(1, 20));
        l = use_fixed ? fix_len   : int'($urandom_range(3, 30));
        repeat (d) @(posedge clk);
        #1 spi_enable = 1'b1;
        repeat (l) @(posedge clk);
        #1 spi_enable = 1'b0;
        ser_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [23:0] w, input bit acc);
    {wr_comm, wr_addr, wr_data} = w;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (acc) begin
      exp_w.push_back(w);
      n_acc++;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (!(n_starts == n_acc && !busy && !ser_active && empty && !spi_enable)
           && n < budget) begin
      tick();
      n++;
    end
    expect_eq(nm, 32'(n < budget), 32'd1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int exp_sent = 0;
    int n, sa, te, sbase, acc0;
    rst = 1'b1; wr_en = 1'b0; run = 1'b0; clr_err = 1'b0;
    wr_comm = '0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    expect_eq("rst_count", 32'(count), 32'd0);
    expect_eq("rst_empty", 32'(empty), 32'd1);
    expect_eq("rst_full",  32'(full),  32'd0);
    expect_eq("rst_busy",  32'(busy),  32'd0);
    expect_eq("rst_word",  32'({dac_comm, dac_addr, dac_data}), 32'd0);
    expect_eq("rst_errs",  32'({err_ovf, err_tmo, dac_start}), 32'd0);
    expect_eq("rst_sent",  32'(sent_cnt), 32'd0);
    rst = 1'b0;
    run = 1'b1;
    tick();

    // ---- single word with fixed frame timing ----
    use_fixed = 1'b1; fix_delay = 40; fix_len = 25;
    push_w({4'd3, 4'd2, 16'hBEEF}, 1'b1);          // now in cycle 1
    expect_eq("t1_empty_c1", 32'(empty), 32'd0);
    expect_eq("t1_count_c1", 32'(count), 32'd1);
    expect_eq("t1_nostart_c1", 32'(dac_start), 32'd0);
    tick();                                         // cycle 2
    expect_eq("t1_start_c2", 32'(dac_start), 32'd1);
    expect_eq("t1_word_c2", 32'({dac_comm, dac_addr, dac_data}), 32'h032BEEF);
    tick();                                         // cycle 3
    expect_eq("t1_start_c3", 32'(dac_start), 32'd0);
    expect_eq("t1_word_held", 32'({dac_comm, dac_addr, dac_data}), 32'h032BEEF);
    n = 0;
    while (sent_cnt != 16'd1 && n < 200) begin tick(); n++; end
    expect_eq("t1_sent_one", 32'(sent_cnt), 32'd1);
    exp_sent = 1;
    repeat (15) tick();
    expect_eq("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    expect_eq("t1_idle_after_gap", 32'(busy), 32'd0);
    use_fixed = 1'b0;
    wait_drain("t1_drain", 500);

    // ---- burst fill, overflow, then dispatch ----
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_w(24'($urandom), 1'b1);
    expect_eq("t2_full", 32'(full), 32'd1);
    expect_eq("t2_count8", 32'(count), 32'd8);
    push_w(24'($urandom), 1'b0);
    expect_eq("t2_ovf", 32'(err_ovf), 32'd1);
    expect_eq("t2_count_stays", 32'(count), 32'd8);
    run = 1'b1;
    wait_drain("t2_drain", 3000);
    exp_sent += DEPTH;
    expect_eq("t2_sent", 32'(sent_cnt), 32'(exp_sent));
    expect_eq("t2_empty", 32'(empty), 32'd1);
    pulse_clr();
    expect_eq("t2_ovf_clr", 32'(err_ovf), 32'd0);

    // ---- timeout ----
    tmo_mode = 1'b1;
    push_w(24'h5A1234, 1'b1);
    push_w(24'h6B5678, 1'b1);
    n = 0;
    while (n_starts != n_acc - 1 && n < 50) begin tick(); n++; end
    sa = last_start_cyc;
    n = 0;
    while (!err_tmo && n < 300) begin @(negedge clk); n++; end
    te = cyc;
    tmo_mode = 1'b0;
    expect_eq("t3_tmo_set", 32'(err_tmo), 32'd1);
    // WAIT_BUSY spans 128 cycles after the start; the flag registers after.
    expect_eq("t3_tmo_latency", 32'(te - sa), 32'd129);
    expect_eq("t3_sent_unchanged", 32'(sent_cnt), 32'(exp_sent));
    n = 0;
    while (n_starts != n_acc && n < 100) begin tick(); n++; end
    expect_eq("t3_next_launch_spacing", 32'(last_start_cyc - sa), 32'd146);
    wait_drain("t3_drain", 500);
    exp_sent += 1;
    expect_eq("t3_sent", 32'(sent_cnt), 32'(exp_sent));
    pulse_clr();
    expect_eq("t3_tmo_clr", 32'(err_tmo), 32'd0);

    // ---- push/pop collision while full ----
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_w(24'($urandom), 1'b1);
    run = 1'b1;
    push_w(24'hC0FFEE, 1'b1);
    expect_eq("t4_count_stays", 32'(count), 32'd8);
    expect_eq("t4_no_ovf", 32'(err_ovf), 32'd0);
    wait_drain("t4_drain", 3000);
    exp_sent += DEPTH + 1;
    expect_eq("t4_sent", 32'(sent_cnt), 32'(exp_sent));

    // ---- reset in WAIT_DONE ----
    use_fixed = 1'b1; fix_delay = 5; fix_len = 30;
    push_w(24'h1ABCDE, 1'b1);
    n = 0;
    while (!spi_enable && n < 100) begin tick(); n++; end
    tick();
    #2 rst = 1'b1;
    #1;
    expect_eq("t5_busy", 32'(busy), 32'd0);
    expect_eq("t5_word", 32'({dac_comm, dac_addr, dac_data}), 32'd0);
    expect_eq("t5_flags", 32'({dac_start, full, empty}), 32'd1);
    expect_eq("t5_sent", 32'(sent_cnt), 32'd0);
    expect_eq("t5_count", 32'(count), 32'd0);
    exp_sent = 0;
    tick(); tick();
    rst = 1'b0;
    sbase = n_starts;
    repeat (100) tick();
    expect_eq("t5_no_start", 32'(n_starts - sbase), 32'd0);
    use_fixed = 1'b0;
    wait_drain("t5_drain", 200);

    // ---- sent_cnt wrap ----
    force dut.r_sent_cnt = 16'hFFFF;
    tick();
    release dut.r_sent_cnt;
    tick();
    expect_eq("t6_preload", 32'(sent_cnt), 32'hFFFF);
    push_w(24'h9F0F0F, 1'b1);
    wait_drain("t6_drain", 300);
    expect_eq("t6_wrap", 32'(sent_cnt), 32'd0);

    // ---- randomized traffic ----
    acc0 = n_acc;
    for (int k = 0; k < 40; k++) begin
      run = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 30)) tick();
      if (n_acc - n_starts < DEPTH - 1) push_w(24'($urandom), 1'b1);
    end
    run = 1'b1;
    wait_drain("rnd_drain", 20000);
    expect_eq("rnd_sent", 32'(sent_cnt), 32'(n_acc - acc0));
    expect_eq("rnd_errs", 32'({err_ovf, err_tmo}), 32'd0);

    tick();
    done = 1'b1;
  end

endmodule
`default_nettype wire
